// File: rtl/interrupt_unit_pkg.sv
// Shared vector addresses, state encodings and helpers
// for the interrupt unit and its priority encoder.
package interrupt_unit_pkg;

  localparam logic [15:0] VEC_RESET    = 16'hFFFE;
  localparam logic [15:0] VEC_NMI      = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ_BASE = 16'hFFE0;

  localparam int IDX_W = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    INT_RESET  = 2'd0,
    INT_IDLE   = 2'd1,
    INT_PEND   = 2'd2,
    INT_LOCKED = 2'd3
  } int_state_e;

  function automatic logic [15:0] irq_vec(
    input logic [IDX_W-1:0] idx
  );
    return VEC_IRQ_BASE + {11'b0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/interrupt_unit_if.sv
// Request/acknowledge bundle between the interrupt unit
// and the CPU control path.
interface interrupt_unit_if #(
  parameter int N_IRQ = 14
) ();

  logic             PUC;
  logic             NMI;
  logic             NMIIE;
  logic [N_IRQ-1:0] IRQ;
  logic             GIE;
  logic             IF;
  logic             VACK;
  logic             rst;
  logic             INTREQ;
  logic [15:0]      VEC;
  logic [N_IRQ-1:0] IACK;
  logic             NMIACK;

  modport master (
    input  PUC, NMI, NMIIE, IRQ, GIE, IF, VACK,
    output rst, INTREQ, VEC, IACK, NMIACK
  );

  modport slave (
    output PUC, NMI, NMIIE, IRQ, GIE, IF, VACK,
    input  rst, INTREQ, VEC, IACK, NMIACK
  );

endinterface

// File: rtl/interrupt_unit_priority_enc.sv
// Fixed-priority arbiter: NMI first, then the highest
// numbered maskable request.
module int_priority_enc
  import interrupt_unit_pkg::*;
#(
  parameter int N_IRQ = 14
) (
  input  logic             nmi,
  input  logic [N_IRQ-1:0] irq,
  output logic             valid,
  output logic             nmi_sel,
  output logic [IDX_W-1:0] idx,
  output logic [15:0]      vec
);

  always_comb begin
    valid   = nmi | (|irq);
    nmi_sel = nmi;
    idx     = '0;
    for (int i = 0; i < N_IRQ; i++)
      if (irq[i]) idx = IDX_W'(i);
    if (nmi)
      vec = VEC_NMI;
    else if (|irq)
      vec = irq_vec(idx);
    else
      vec = '0;
  end

endmodule

// File: rtl/interrupt_unit.sv
// Reset sequencing, NMI capture and interrupt arbitration.
// Define INT_SYNC_EN to add 2-flop input synchronizers.
module interrupt_unit
  import interrupt_unit_pkg::*;
#(
  parameter int N_IRQ      = 14,
  parameter int RST_CYCLES = 4
) (
  input logic          clk,
  input logic          rst_n,
  interrupt_unit_if.master bus
);

  int_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             nmi_pend;
  logic             nmi_prev;
  logic             lock_nmi;
  logic [IDX_W-1:0] lock_idx;
  logic [15:0]      lock_vec;
  logic [N_IRQ-1:0] iack;
  logic             nmiack;

  logic             nmi_s;
  logic [N_IRQ-1:0] irq_s;

`ifdef INT_SYNC_EN
  logic [1:0]       nmi_sy;
  logic [N_IRQ-1:0] irq_sy0;
  logic [N_IRQ-1:0] irq_sy1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_sy  <= '0;
      irq_sy0 <= '0;
      irq_sy1 <= '0;
    end else begin
      nmi_sy  <= {nmi_sy[0], bus.NMI};
      irq_sy0 <= bus.IRQ;
      irq_sy1 <= irq_sy0;
    end
  end

  assign nmi_s = nmi_sy[1];
  assign irq_s = irq_sy1;
`else
  assign nmi_s = bus.NMI;
  assign irq_s = bus.IRQ;
`endif

  logic             nmi_edge;
  logic             nmi_hot;
  logic [N_IRQ-1:0] irq_hot;
  logic             enc_valid;
  logic             enc_nmi;
  logic [IDX_W-1:0] enc_idx;
  logic [15:0]      enc_vec;

  // A fresh edge is serviceable in the cycle it is seen
  assign nmi_edge = nmi_s & ~nmi_prev;
  assign nmi_hot  = (nmi_pend | nmi_edge) & bus.NMIIE;
  assign irq_hot  = irq_s & {N_IRQ{bus.GIE}};

  int_priority_enc #(
    .N_IRQ (N_IRQ)
  ) u_enc (
    .nmi     (nmi_hot),
    .irq     (irq_hot),
    .valid   (enc_valid),
    .nmi_sel (enc_nmi),
    .idx     (enc_idx),
    .vec     (enc_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INT_RESET;
      cnt      <= RST_CYCLES[CNT_W-1:0];
      nmi_pend <= 1'b0;
      nmi_prev <= 1'b0;
      lock_nmi <= 1'b0;
      lock_idx <= '0;
      lock_vec <= '0;
      iack     <= '0;
      nmiack   <= 1'b0;
    end else begin
      nmi_prev <= nmi_s;
      iack     <= '0;
      nmiack   <= 1'b0;
      if (bus.PUC) begin
        state    <= INT_RESET;
        cnt      <= RST_CYCLES[CNT_W-1:0];
        nmi_pend <= 1'b0;
        lock_nmi <= 1'b0;
        lock_idx <= '0;
        lock_vec <= '0;
      end else begin
        if (state != INT_RESET && nmi_edge)
          nmi_pend <= 1'b1;
        unique case (state)
          INT_RESET: begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1))
              state <= INT_IDLE;
          end
          INT_IDLE: begin
            if (enc_valid)
              state <= INT_PEND;
          end
          INT_PEND: begin
            if (!enc_valid) begin
              state <= INT_IDLE;
            end else if (bus.IF) begin
              state    <= INT_LOCKED;
              lock_nmi <= enc_nmi;
              lock_idx <= enc_idx;
              lock_vec <= enc_vec;
            end
          end
          INT_LOCKED: begin
            if (bus.VACK) begin
              state <= INT_IDLE;
              if (lock_nmi) begin
                nmiack <= 1'b1;
                if (!nmi_edge)
                  nmi_pend <= 1'b0;
              end else begin
                for (int i = 0; i < N_IRQ; i++)
                  iack[i] <= (lock_idx == IDX_W'(i));
              end
            end
          end
        endcase
      end
    end
  end

  logic [15:0] vec;

  always_comb begin
    vec = '0;
    unique case (state)
      INT_RESET:  vec = VEC_RESET;
      INT_IDLE:   vec = '0;
      INT_PEND:   vec = enc_vec;
      INT_LOCKED: vec = lock_vec;
    endcase
  end

  assign bus.rst    = (state == INT_RESET);
  assign bus.INTREQ = (state == INT_PEND);
  assign bus.VEC    = vec;
  assign bus.IACK   = iack;
  assign bus.NMIACK = nmiack;

endmodule

// File: tb/tb_interrupt_unit.sv
// Directed plus randomized check of interrupt_unit against
// a behavioural model of the request/lock/ack rules.
module tb_interrupt_unit;

  localparam int N   = 14;
  localparam int RST = 4;
`ifdef INT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;

  interrupt_unit_if #(.N_IRQ(N)) bus ();

  interrupt_unit #(
    .N_IRQ      (N),
    .RST_CYCLES (RST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_rleft = RST;
  bit          m_pend  = 0;
  bit          m_prev  = 0;
  bit          m_req   = 0;
  bit          m_lock  = 0;
  bit          m_lnmi  = 0;
  int          m_lidx  = 0;
  logic [15:0] m_lvec  = '0;
  logic [N-1:0] m_iack = '0;
  bit          m_nmiack = 0;
  logic        m_nd1 = 0, m_nd2 = 0;
  logic [N-1:0] m_id1 = '0, m_id2 = '0;

  function automatic logic nmi_cur();
`ifdef INT_SYNC_EN
    return m_nd2;
`else
    return bus.NMI;
`endif
  endfunction

  function automatic logic [N-1:0] irq_cur();
`ifdef INT_SYNC_EN
    return m_id2;
`else
    return bus.IRQ;
`endif
  endfunction

  function automatic int top_idx(logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++)
      if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [15:0] win(logic hn, logic [N-1:0] hi);
    int t;
    if (hn) return 16'hFFFC;
    t = top_idx(hi);
    if (t < 0) return 16'h0000;
    return 16'hFFE0 + 16'(2 * t);
  endfunction

  function automatic logic [15:0] exp_vec();
    logic hn;
    logic [N-1:0] hi;
    if (m_rleft > 0) return 16'hFFFE;
    if (m_lock) return m_lvec;
    if (!m_req) return 16'h0000;
    hn = (m_pend || (nmi_cur() && !m_prev)) && bus.NMIIE;
    hi = bus.GIE ? irq_cur() : '0;
    return win(hn, hi);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic nv, edg, hn, any;
    logic [N-1:0] iv, hi;
    if (!rst_n) begin
      m_rleft = RST; m_pend = 0; m_prev = 0;
      m_req = 0; m_lock = 0; m_lnmi = 0;
      m_lidx = 0; m_lvec = '0;
      m_iack = '0; m_nmiack = 0;
      m_nd1 = 0; m_nd2 = 0; m_id1 = '0; m_id2 = '0;
    end else begin
      nv  = nmi_cur();
      iv  = irq_cur();
      edg = nv && !m_prev;
      hn  = (m_pend || edg) && bus.NMIIE;
      hi  = bus.GIE ? iv : '0;
      any = hn || (hi != 0);
      m_iack = '0;
      m_nmiack = 0;
      if (bus.PUC) begin
        m_rleft = RST; m_pend = 0; m_req = 0; m_lock = 0;
      end else if (m_rleft > 0) begin
        m_rleft--;
      end else begin
        if (edg) m_pend = 1;
        if (m_lock) begin
          if (bus.VACK) begin
            m_lock = 0;
            if (m_lnmi) begin
              m_nmiack = 1;
              m_pend = edg;
            end else begin
              m_iack[m_lidx] = 1'b1;
            end
          end
        end else if (m_req) begin
          if (!any) m_req = 0;
          else if (bus.IF) begin
            m_req = 0; m_lock = 1;
            m_lnmi = hn;
            m_lidx = top_idx(hi);
            m_lvec = win(hn, hi);
          end
        end else if (any) begin
          m_req = 1;
        end
      end
      m_prev = nv;
      m_nd2 = m_nd1; m_nd1 = bus.NMI;
      m_id2 = m_id1; m_id1 = bus.IRQ;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    cmp("rst", 32'(bus.rst), 32'(m_rleft > 0));
    cmp("intreq", 32'(bus.INTREQ), 32'(m_req));
    cmp("vec", 32'(bus.VEC), 32'(exp_vec()));
    cmp("iack", 32'(bus.IACK), 32'(m_iack));
    cmp("nmiack", 32'(bus.NMIACK), 32'(m_nmiack));
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rst_window(string nm);
    for (int k = 0; k < RST; k++) begin
      @(negedge clk);
      cmp({nm, "_rst_hi"}, 32'(bus.rst), 32'd1);
      cmp({nm, "_vec"}, 32'(bus.VEC), 32'hFFFE);
    end
    @(negedge clk);
    cmp({nm, "_rst_lo"}, 32'(bus.rst), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.PUC = 0; bus.NMI = 0; bus.NMIIE = 0;
    bus.IRQ = '0; bus.GIE = 0; bus.IF = 0; bus.VACK = 0;
    tick(2);
    @(negedge clk);
    cmp("por_rst", 32'(bus.rst), 32'd1);
    cmp("por_intreq", 32'(bus.INTREQ), 32'd0);
    cmp("por_vec", 32'(bus.VEC), 32'hFFFE);
    cmp("por_acks", 32'({bus.IACK, bus.NMIACK}), 32'd0);
    tick();
    rst_n = 1'b1;
    rst_window("por");

    // IRQ 0x0005 -> vector FFE4, ack bit 2
    tick();
    bus.GIE = 1; bus.IRQ = 14'h0005;
    repeat (LAT) @(negedge clk);
    cmp("lat_before", 32'(bus.INTREQ), 32'd0);
    @(negedge clk);
    cmp("lat_intreq", 32'(bus.INTREQ), 32'd1);
    cmp("irq5_vec", 32'(bus.VEC), 32'hFFE4);
    cmp("model_irq5_vec", 32'(exp_vec()), 32'hFFE4);
    tick(); bus.IF = 1;
    tick(); bus.IF = 0; bus.VACK = 1;
    tick(); bus.VACK = 0;
    cmp("irq5_iack", 32'(bus.IACK), 32'h0004);
    cmp("irq5_intreq", 32'(bus.INTREQ), 32'd0);
    bus.IRQ = '0;
    tick();
    cmp("irq5_iack_pulse", 32'(bus.IACK), 32'h0000);
    tick(6);

    // NMI preempts IRQ3 before IF, then stays frozen
    bus.NMIIE = 1; bus.IRQ = 14'h0008;
    tick(LAT + 2);
    @(negedge clk);
    cmp("irq3_vec", 32'(bus.VEC), 32'hFFE6);
    tick(); bus.NMI = 1;
    repeat (LAT) @(negedge clk);
    cmp("nmi_pre_vec", 32'(bus.VEC), 32'hFFFC);
    tick(); bus.IF = 1;
    tick(); bus.IF = 0; bus.IRQ = 14'h2008;
    @(negedge clk);
    cmp("lock_vec", 32'(bus.VEC), 32'hFFFC);
    cmp("lock_intreq", 32'(bus.INTREQ), 32'd0);
    cmp("model_lock_vec", 32'(exp_vec()), 32'hFFFC);
    tick(); bus.VACK = 1;
    tick(); bus.VACK = 0;
    cmp("nmiack", 32'(bus.NMIACK), 32'd1);
    cmp("nmi_no_iack", 32'(bus.IACK), 32'd0);
    tick();
    cmp("nmiack_pulse", 32'(bus.NMIACK), 32'd0);
    bus.IRQ = '0; bus.NMI = 0;
    tick(6);

    // Masked sources, then NMIIE releases a pending NMI
    bus.GIE = 0; bus.NMIIE = 0; bus.IRQ = 14'h3FFF;
    tick(5);
    @(negedge clk);
    cmp("gie0_intreq", 32'(bus.INTREQ), 32'd0);
    tick(); bus.NMI = 1;
    tick(5);
    @(negedge clk);
    cmp("nmiie0_intreq", 32'(bus.INTREQ), 32'd0);
    tick(); bus.NMIIE = 1;
    @(posedge clk);
    @(negedge clk);
    cmp("nmiie1_intreq", 32'(bus.INTREQ), 32'd1);
    cmp("nmiie1_vec", 32'(bus.VEC), 32'hFFFC);
    cmp("model_nmiie1", 32'(m_req), 32'd1);

    // PUC together with VACK in LOCKED
    tick(); bus.IF = 1;
    tick(); bus.IF = 0; bus.PUC = 1; bus.VACK = 1;
    tick(); bus.PUC = 0; bus.VACK = 0;
    cmp("puc_rst", 32'(bus.rst), 32'd1);
    cmp("puc_no_ack", 32'({bus.IACK, bus.NMIACK}), 32'd0);
    rst_window("puc");
    bus.GIE = 0;
    tick(3);
    @(negedge clk);
    cmp("puc_pend_clr", 32'(bus.INTREQ), 32'd0);

    // Mid-run asynchronous reset
    tick(); rst_n = 1'b0;
    tick(2); rst_n = 1'b1;
    rst_window("mid");

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 499) != 0);
      bus.PUC = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 5) == 0) bus.NMI = ~bus.NMI;
      bus.NMIIE = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0)
        bus.IRQ = ($urandom_range(0, 2) == 0) ? '0
                : N'($urandom) & N'($urandom);
      bus.GIE = ($urandom_range(0, 4) != 0);
      bus.IF = ($urandom_range(0, 2) == 0);
      bus.VACK = ($urandom_range(0, 2) == 0);
    end
    tick(); rst_n = 1'b1;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
